sdram_read_cache: RTL and testbench

- Direct-mapped, write-through, write-allocate word cache on the CPU-side SDRAM path.
- Sits between the CADR xbus_sdram port (upstream) and the DDR3-backed RAM controller's sdram_* port (downstream).
- Serves repeated reads from block RAM without a DDR round trip.
- Addresses at or above UNCACHED_BASE bypass the cache.

---
 rtl/sdram_cache_pkg.sv | 32 +++
 rtl/sdram_cache_ram.sv | 28 ++
 rtl/sdram_read_cache.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_read_cache.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cache_pkg.sv
// Shared types and constants for the CPU-side SDRAM word cache.
// Contents: FSM state enum, default geometry, address-field width helpers.
package sdram_cache_pkg;

  localparam int unsigned XbusAddrBits = 22;
  localparam int unsigned XbusDataBits = 32;

  localparam int unsigned DefIndexBits    = 10;
  localparam logic [21:0] DefUncachedBase = 22'h3C0000;

  typedef enum logic [3:0] {
    StFlush,
    StIdle,
    StLookup,
    StHit,
    StMissReq,
    StBypassRd,
    StWrReq,
    StBypassWr,
    StRelease
  } state_e;

  function automatic int unsigned tag_bits(input int unsigned index_bits);
    return XbusAddrBits - index_bits;
  endfunction

  // One line = {valid, tag, data}.
  function automatic int unsigned line_bits(input int unsigned index_bits);
    return 1 + tag_bits(index_bits) + XbusDataBits;
  endfunction

endpackage

// File: rtl/sdram_cache_ram.sv
// Single-port synchronous RAM for cache lines, written to infer block RAM.
// Ports: cpu_clk clock; we write enable; addr line index; wdata line to write;
//        rdata line read at addr, registered (old contents on a write cycle).
module sdram_cache_ram
  import sdram_cache_pkg::*;
#(
  parameter int unsigned Width     = 45,
  parameter int unsigned IndexBits = 10
) (
  input  logic                 cpu_clk,
  input  logic                 we,
  input  logic [IndexBits-1:0] addr,
  input  logic [Width-1:0]     wdata,
  output logic [Width-1:0]     rdata
);

  localparam int unsigned Depth = 1 << IndexBits;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge cpu_clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_read_cache.sv
// Direct-mapped, write-through, write-allocate one-word-per-line cache between
// the xbus SDRAM port (up_*) and the DDR3 RAM controller port (mem_*).
// Addresses >= UNCACHED_BASE bypass the cache. After reset the valid bits are
// cleared one index per cycle while busy=1; requests wait until busy drops.
// Ports: cpu_clk, reset (sync, active-high); up_addr/up_data_in/up_req/up_write
//        in, up_data_out/up_ready/up_done out; mem_addr/mem_data_out/mem_req/
//        mem_write out, mem_data_in/mem_ready/mem_done in; busy out.
// Optional: define SDRAM_CACHE_STATS_EN to add saturating hit_count/miss_count.
module sdram_read_cache
  import sdram_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS    = DefIndexBits,
  parameter logic [21:0] UNCACHED_BASE = DefUncachedBase
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [21:0] up_addr,
  input  logic [31:0] up_data_in,
  output logic [31:0] up_data_out,
  input  logic        up_req,
  input  logic        up_write,
  output logic        up_ready,
  output logic        up_done,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic        mem_req,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic        mem_done,
  output logic        busy
`ifdef SDRAM_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned TagBits  = tag_bits(INDEX_BITS);
  localparam int unsigned LineBits = line_bits(INDEX_BITS);

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] flush_q, flush_d;
  logic [21:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  op_write_q, op_write_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic                  ram_we;
  logic [INDEX_BITS-1:0] ram_addr;
  logic [LineBits-1:0]   ram_wdata, ram_rdata;
  logic                  line_valid;
  logic [TagBits-1:0]    line_tag;
  logic [31:0]           line_data;
  logic                  hit;

  sdram_cache_ram #(
    .Width     (LineBits),
    .IndexBits (INDEX_BITS)
  ) u_ram (
    .cpu_clk (cpu_clk),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  assign {line_valid, line_tag, line_data} = ram_rdata;
  assign hit = line_valid && (line_tag == addr_q[21:INDEX_BITS]);

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    op_write_d = op_write_q;
    ready_d    = ready_q;
    done_d     = done_q;
    ram_we     = 1'b0;
    ram_addr   = addr_q[INDEX_BITS-1:0];
    ram_wdata  = {1'b1, addr_q[21:INDEX_BITS], wdata_q};
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      StFlush: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = flush_q;
        ram_wdata = '0;
        flush_d   = flush_q + 1'b1;
        if (flush_q == '1) state_d = StIdle;
      end
      StIdle: begin
        // Present the incoming index now so the line is readable in StLookup.
        ram_addr = up_addr[INDEX_BITS-1:0];
        if (up_req || up_write) begin
          addr_d     = up_addr;
          wdata_d    = up_data_in;
          op_write_d = !up_req;
          if (up_addr >= UNCACHED_BASE) begin
            state_d = up_req ? StBypassRd : StBypassWr;
          end else begin
            state_d = StLookup;
          end
        end
      end
      StLookup: begin
        if (op_write_q) begin
          // Write-allocate: the line takes the new word whether or not it hit.
          ram_we  = 1'b1;
          state_d = StWrReq;
        end else if (hit) begin
          rdata_d = line_data;
          ready_d = 1'b1;
          state_d = StHit;
        end else begin
          state_d = StMissReq;
        end
      end
      StHit: state_d = StRelease;
      StMissReq, StBypassRd: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          rdata_d = mem_data_in;
          ready_d = 1'b1;
          state_d = StRelease;
          if (state_q == StMissReq) begin
            ram_we    = 1'b1;
            ram_wdata = {1'b1, addr_q[21:INDEX_BITS], mem_data_in};
          end
        end
      end
      StWrReq, StBypassWr: begin
        mem_write = 1'b1;
        if (mem_done) begin
          done_d  = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (ready_q && !up_req)  ready_d = 1'b0;
        if (done_q && !up_write) done_d  = 1'b0;
        // Leave only once the controller has also retired its handshake.
        if (!ready_d && !done_d && !mem_ready && !mem_done) state_d = StIdle;
      end
      default: state_d = StFlush;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q    <= StFlush;
      flush_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      op_write_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      op_write_q <= op_write_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign up_data_out  = rdata_q;
  assign up_ready     = ready_q;
  assign up_done      = done_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;

`ifdef SDRAM_CACHE_STATS_EN
  logic count_hit, count_miss;

  // StLookup is only entered for cacheable addresses, so bypass is excluded.
  assign count_hit  = (state_q == StLookup) && !op_write_q && hit;
  assign count_miss = (state_q == StLookup) && !op_write_q && !hit;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (count_hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (count_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_read_cache.sv
// Self-checking bench for sdram_read_cache: vector table of reads/writes with a
// read-data scoreboard, a behavioural RAM controller, and hand-written
// sequences for flush, simultaneous read/write and reset during a miss.
module tb_sdram_read_cache;

  logic        cpu_clk;
  logic        reset;
  logic [21:0] up_addr;
  logic [31:0] up_data_in;
  logic [31:0] up_data_out;
  logic        up_req;
  logic        up_write;
  logic        up_ready;
  logic        up_done;
  logic [21:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_req;
  logic        mem_write;
  logic        mem_ready;
  logic        mem_done;
  logic        busy;
`ifdef SDRAM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  sdram_read_cache dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .up_addr      (up_addr),
    .up_data_in   (up_data_in),
    .up_data_out  (up_data_out),
    .up_req       (up_req),
    .up_write     (up_write),
    .up_ready     (up_ready),
    .up_done      (up_done),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .mem_ready    (mem_ready),
    .mem_done     (mem_done),
    .busy         (busy)
`ifdef SDRAM_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  // ref_mem: what memory must hold according to the bench's own writes.
  // dev_mem: what the controller model actually stored from the DUT.
  logic [31:0] ref_mem [logic [21:0]];
  logic [31:0] dev_mem [logic [21:0]];
  logic [31:0] sb_q [$];
  logic [31:0] last_read = 32'h0;

  int          mem_lat = 3;
  int          rd_lat = 0;
  int          wr_lat = 0;
  logic [21:0] last_wr_addr = 22'h0;
  logic [31:0] last_wr_data = 32'h0;
  int          req_pulses = 0;
  int          wr_pulses = 0;
  int          overlap = 0;
  logic        req_prev = 1'b0;
  logic        wr_prev = 1'b0;

  function automatic logic [31:0] init_val(input logic [21:0] a);
    return {a[9:0], a} ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [21:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [21:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Controller model: answers each request after mem_lat cycles, holds the
  // handshake until the DUT drops its request.
  always @(negedge cpu_clk) begin
    if (!mem_req) begin
      mem_ready = 1'b0;
      rd_lat    = 0;
    end else if (!mem_ready) begin
      rd_lat++;
      if (rd_lat >= mem_lat) begin
        mem_ready   = 1'b1;
        mem_data_in = dev_rd(mem_addr);
      end
    end
    if (!mem_write) begin
      mem_done = 1'b0;
      wr_lat   = 0;
    end else if (!mem_done) begin
      wr_lat++;
      if (wr_lat >= mem_lat) begin
        mem_done          = 1'b1;
        dev_mem[mem_addr] = mem_data_out;
        last_wr_addr      = mem_addr;
        last_wr_data      = mem_data_out;
      end
    end
  end

  always @(posedge cpu_clk) begin
    #1;
    if (mem_req && !req_prev)   req_pulses++;
    if (mem_write && !wr_prev)  wr_pulses++;
    if (mem_req && mem_write)   overlap++;
    req_prev = mem_req;
    wr_prev  = mem_write;
  end

  task automatic do_read(input logic [21:0] a, input int exp_reqs, input int exp_lat);
    int          req0, wr0, lat;
    bit          got;
    logic [31:0] exp;
`ifdef SDRAM_CACHE_STATS_EN
    logic [31:0] h0, m0;
    h0 = hit_count;
    m0 = miss_count;
`endif
    req0 = req_pulses;
    wr0  = wr_pulses;
    sb_q.push_back(ref_rd(a));
    up_addr = a;
    up_req  = 1'b1;
    lat     = 0;
    got     = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge cpu_clk);
      lat++;
      @(negedge cpu_clk);
      if (up_ready) got = 1'b1;
    end
    check("read_ready", 64'(got), 64'd1);
    exp = sb_q.pop_front();
    if (got) begin
      check("read_data", 64'(up_data_out), 64'(exp));
      last_read = exp;
    end
    up_req = 1'b0;
    for (int i = 0; i < 50 && up_ready; i++) @(negedge cpu_clk);
    check("read_ready_release", 64'(up_ready), 64'd0);
    @(negedge cpu_clk);
    check("read_mem_req_pulses", 64'(req_pulses - req0), 64'(exp_reqs));
    check("read_no_mem_write", 64'(wr_pulses - wr0), 64'd0);
    if (exp_lat > 0) check("read_hit_latency", 64'(lat), 64'(exp_lat));
`ifdef SDRAM_CACHE_STATS_EN
    if (a >= 22'h3C0000) begin
      check("bypass_hits", 64'(hit_count), 64'(h0));
      check("bypass_misses", 64'(miss_count), 64'(m0));
    end else if (exp_reqs == 0) begin
      check("hit_count", 64'(hit_count), 64'(h0 + 32'd1));
      check("hit_misses", 64'(miss_count), 64'(m0));
    end else begin
      check("miss_hits", 64'(hit_count), 64'(h0));
      check("miss_count", 64'(miss_count), 64'(m0 + 32'd1));
    end
`endif
  endtask

  task automatic do_write(input logic [21:0] a, input logic [31:0] d);
    int req0, wr0;
    bit got;
    req0 = req_pulses;
    wr0  = wr_pulses;
    ref_mem[a] = d;
    up_addr    = a;
    up_data_in = d;
    up_write   = 1'b1;
    got        = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge cpu_clk);
      if (up_done) got = 1'b1;
    end
    check("write_done", 64'(got), 64'd1);
    up_write = 1'b0;
    for (int i = 0; i < 50 && up_done; i++) @(negedge cpu_clk);
    check("write_done_release", 64'(up_done), 64'd0);
    @(negedge cpu_clk);
    check("write_mem_write_pulses", 64'(wr_pulses - wr0), 64'd1);
    check("write_no_mem_req", 64'(req_pulses - req0), 64'd0);
    check("write_mem_addr", 64'(last_wr_addr), 64'(a));
    check("write_mem_data", 64'(last_wr_data), 64'(d));
    check("write_holds_read_data", 64'(up_data_out), 64'(last_read));
  endtask

  typedef struct {
    bit          wr;
    logic [21:0] addr;
    logic [31:0] wdata;
    int          reqs;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int   busy_n, early, req0, wr0;
    bit   got;
    logic [31:0] exp;

    reset = 1'b1; up_addr = '0; up_data_in = '0; up_req = 1'b0; up_write = 1'b0;
    mem_data_in = '0; mem_ready = 1'b0; mem_done = 1'b0;
    ref_mem[22'h000123] = 32'hDEADBEEF; dev_mem[22'h000123] = 32'hDEADBEEF;
    ref_mem[22'h000523] = 32'hCAFEF00D; dev_mem[22'h000523] = 32'hCAFEF00D;
    ref_mem[22'h3C0010] = 32'h0BADC0DE; dev_mem[22'h3C0010] = 32'h0BADC0DE;

    //            wr    addr         wdata         reqs lat
    vecs[0]  = '{1'b0, 22'h000123, 32'h0,        1, 0};  // cold miss
    vecs[1]  = '{1'b0, 22'h000123, 32'h0,        0, 2};  // hit
    vecs[2]  = '{1'b1, 22'h000123, 32'h12345678, 0, 0};
    vecs[3]  = '{1'b0, 22'h000123, 32'h0,        0, 2};  // hit, new data
    vecs[4]  = '{1'b0, 22'h000523, 32'h0,        1, 0};  // alias evicts 123
    vecs[5]  = '{1'b0, 22'h000123, 32'h0,        1, 0};  // alias evicts 523
    vecs[6]  = '{1'b0, 22'h000523, 32'h0,        1, 0};
    vecs[7]  = '{1'b0, 22'h3C0010, 32'h0,        1, 0};  // bypass
    vecs[8]  = '{1'b0, 22'h3C0010, 32'h0,        1, 0};  // bypass, never cached
    vecs[9]  = '{1'b1, 22'h3C0020, 32'h0000BEEF, 0, 0};  // bypass write
    vecs[10] = '{1'b0, 22'h3C0020, 32'h0,        1, 0};
    vecs[11] = '{1'b1, 22'h000200, 32'hAAAA5555, 0, 0};  // write-allocate on miss
    vecs[12] = '{1'b0, 22'h000200, 32'h0,        0, 2};

    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_up_ready", 64'(up_ready), 64'd0);
    check("reset_up_done", 64'(up_done), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_write", 64'(mem_write), 64'd0);
    check("reset_up_data_out", 64'(up_data_out), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_mem_data_out", 64'(mem_data_out), 64'd0);

    // Flush length, with a read held pending across it.
    reset   = 1'b0;
    up_addr = 22'h000010;
    up_req  = 1'b1;
    sb_q.push_back(ref_rd(22'h000010));
    busy_n = 0;
    early  = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      if (up_ready) early++;
      busy_n++;
      @(negedge cpu_clk);
    end
    check("flush_busy_cycles", 64'(busy_n), 64'd1024);
    check("no_ready_while_busy", 64'(early), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge cpu_clk);
      if (up_ready) got = 1'b1;
    end
    check("post_flush_ready", 64'(got), 64'd1);
    exp = sb_q.pop_front();
    check("post_flush_data", 64'(up_data_out), 64'(exp));
    last_read = exp;
    up_req = 1'b0;
    for (int i = 0; i < 50 && up_ready; i++) @(negedge cpu_clk);
    @(negedge cpu_clk);

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].wdata);
      else            do_read(vecs[v].addr, vecs[v].reqs, vecs[v].lat);
    end

    // Read and write raised together: the read goes first.
    req0       = req_pulses;
    wr0        = wr_pulses;
    up_addr    = 22'h000300;
    up_data_in = 32'h11112222;
    up_req     = 1'b1;
    up_write   = 1'b1;
    got        = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge cpu_clk);
      if (up_ready) got = 1'b1;
    end
    check("both_read_ready", 64'(got), 64'd1);
    check("both_read_data", 64'(up_data_out), 64'(ref_rd(22'h000300)));
    check("both_no_mem_write", 64'(wr_pulses - wr0), 64'd0);
    check("both_one_mem_req", 64'(req_pulses - req0), 64'd1);
    check("both_no_up_done", 64'(up_done), 64'd0);
    last_read = ref_rd(22'h000300);
    up_req   = 1'b0;
    up_write = 1'b0;
    for (int i = 0; i < 50 && up_ready; i++) @(negedge cpu_clk);
    @(negedge cpu_clk);

    // Reset while a miss is outstanding.
    mem_lat = 20;
    up_addr = 22'h000400;
    up_req  = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge cpu_clk);
      if (mem_req) got = 1'b1;
    end
    check("miss_req_seen", 64'(got), 64'd1);
    reset  = 1'b1;
    up_req = 1'b0;
    @(negedge cpu_clk);
    check("reset_mid_mem_req", 64'(mem_req), 64'd0);
    check("reset_mid_busy", 64'(busy), 64'd1);
    check("reset_mid_up_ready", 64'(up_ready), 64'd0);
    reset   = 1'b0;
    mem_lat = 3;
    busy_n  = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      busy_n++;
      @(negedge cpu_clk);
    end
    check("reflush_busy_cycles", 64'(busy_n), 64'd1024);
    last_read = 32'h0;
    do_read(22'h000400, 1, 0);
    do_read(22'h000400, 0, 2);

    check("mem_req_write_overlap", 64'(overlap), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
